// File: rtl/spi_pwm_config_ctrl.sv
// spi_pwm_config_ctrl
//   Write-only SPI target (mode 0, MSB first) that holds the PWM peripheral
//   configuration registers. Each 16-bit frame {rw, addr[6:0], data[7:0]} is
//   committed atomically when ncs rises. Frames that are not exactly 16 bits
//   long, or writes above ADDR_MAX, are discarded with an err_strobe pulse.
//   Read frames are accepted silently and have no effect.
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   sclk, copi, ncs   SPI pins, asynchronous to clk
//   en_reg_out_7_0    addr 0x00     en_reg_out_15_8  addr 0x01
//   en_reg_pwm_7_0    addr 0x02     en_reg_pwm_15_8  addr 0x03
//   pwm_duty_cycle    addr 0x04
//   wr_strobe         one-cycle pulse when a register is written
//   err_strobe        one-cycle pulse when a frame is discarded
module spi_pwm_config_ctrl #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned ADDR_MAX    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       copi,
   input  logic       ncs,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle,
   output logic       wr_strobe,
   output logic       err_strobe
);

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   localparam logic [6:0] ADDR_LIM = 7'(ADDR_MAX);
   localparam logic [4:0] CNT_SAT  = 5'd17;

   logic [SYNC_STAGES-1:0] sclk_sy, copi_sy, ncs_sy;
   logic                   sclk_s, copi_s, ncs_s;
   logic                   sclk_h, ncs_h;
   logic                   sclk_rise_q, ncs_rise_q, ncs_fall_q, copi_q;

   state_t                 state_q, state_d;
   logic [15:0]            shifter;
   logic [4:0]             bit_cnt;
   logic                   do_write, do_err;
   logic [6:0]             addr;

   assign sclk_s = sclk_sy[SYNC_STAGES-1];
   assign copi_s = copi_sy[SYNC_STAGES-1];
   assign ncs_s  = ncs_sy[SYNC_STAGES-1];
   assign addr   = shifter[14:8];

   // Synchronisers, history flops, and registered edge pulses. The ncs chain
   // resets low so that releasing reset mid-frame cannot fake a falling edge;
   // a spurious rising edge only lands in IDLE and is ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sy     <= '0;
         copi_sy     <= '0;
         ncs_sy      <= '0;
         sclk_h      <= 1'b0;
         ncs_h       <= 1'b0;
         sclk_rise_q <= 1'b0;
         ncs_rise_q  <= 1'b0;
         ncs_fall_q  <= 1'b0;
         copi_q      <= 1'b0;
      end else begin
         sclk_sy     <= {sclk_sy[SYNC_STAGES-2:0], sclk};
         copi_sy     <= {copi_sy[SYNC_STAGES-2:0], copi};
         ncs_sy      <= {ncs_sy[SYNC_STAGES-2:0], ncs};
         sclk_h      <= sclk_s;
         ncs_h       <= ncs_s;
         sclk_rise_q <= sclk_s & ~sclk_h;
         ncs_rise_q  <= ncs_s & ~ncs_h;
         ncs_fall_q  <= ~ncs_s & ncs_h;
         copi_q      <= copi_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      do_write = 1'b0;
      do_err   = 1'b0;
      case (state_q)
         IDLE:   if (ncs_fall_q) state_d = SHIFT;
         SHIFT:  if (ncs_rise_q) state_d = COMMIT;
         COMMIT: begin
            // A new frame may already have started while committing.
            state_d = ncs_fall_q ? SHIFT : IDLE;
            if (bit_cnt != 5'd16)    do_err   = 1'b1;
            else if (!shifter[15])   ;
            else if (addr > ADDR_LIM) do_err  = 1'b1;
            else                     do_write = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // An sclk edge arriving with the ncs rise is still shifted here, so COMMIT
   // sees the complete frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shifter <= '0;
         bit_cnt <= '0;
      end else if (state_q != SHIFT && state_d == SHIFT) begin
         shifter <= '0;
         bit_cnt <= '0;
      end else if (state_q == SHIFT && sclk_rise_q) begin
         shifter <= {shifter[14:0], copi_q};
         if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 5'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_reg_out_7_0  <= '0;
         en_reg_out_15_8 <= '0;
         en_reg_pwm_7_0  <= '0;
         en_reg_pwm_15_8 <= '0;
         pwm_duty_cycle  <= '0;
         wr_strobe       <= 1'b0;
         err_strobe      <= 1'b0;
      end else begin
         wr_strobe  <= do_write;
         err_strobe <= do_err;
         if (do_write) begin
            case (addr)
               7'd0:    en_reg_out_7_0  <= shifter[7:0];
               7'd1:    en_reg_out_15_8 <= shifter[7:0];
               7'd2:    en_reg_pwm_7_0  <= shifter[7:0];
               7'd3:    en_reg_pwm_15_8 <= shifter[7:0];
               7'd4:    pwm_duty_cycle  <= shifter[7:0];
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_pwm_config_ctrl.sv
module tb_spi_pwm_config_ctrl;

   localparam int SYNC_STAGES = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sclk = 1'b0;
   logic       copi = 1'b0;
   logic       ncs = 1'b1;
   logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
   logic       wr_strobe, err_strobe;
   logic [39:0] regs_act;

   int total = 0;
   int bad = 0;
   int wr_cnt = 0;
   int err_cnt = 0;

   spi_pwm_config_ctrl #(.SYNC_STAGES(SYNC_STAGES), .ADDR_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
      .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
      .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
      .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe), .err_strobe(err_strobe)
   );

   always #5 clk = ~clk;

   assign regs_act = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};

   always @(negedge clk) begin
      if (wr_strobe)  wr_cnt++;
      if (err_strobe) err_cnt++;
   end

   typedef struct {
      logic [15:0] word;
      int          nbits;
      logic [39:0] exp_regs;   // {duty, pwm15, pwm7, out15, out7}
      int          exp_wr;
      int          exp_err;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drops ncs, clocks n bits MSB first (bits past 16 are 1), leaves ncs low.
   task automatic send_bits(input logic [15:0] w, input int n);
      ncs = 1'b0;
      tick(4);
      for (int i = 0; i < n; i++) begin
         if (i < 16) copi = w[15-i];
         else        copi = 1'b1;
         tick(4);
         sclk = 1'b1;
         tick(4);
         sclk = 1'b0;
      end
      tick(4);
   endtask

   task automatic frame(input logic [15:0] w, input int n, input int gap);
      send_bits(w, n);
      ncs = 1'b1;
      tick(gap);
   endtask

   initial begin
      int wr0, err0, k;
      logic [7:0] sb [5];
      logic [7:0] d;

      vecs[0] = '{16'h80A5, 16, 40'h00_00_00_00_A5, 1, 0};
      vecs[1] = '{16'h8480, 16, 40'h80_00_00_00_A5, 1, 0};
      vecs[2] = '{16'h84FF, 16, 40'hFF_00_00_00_A5, 1, 0};
      vecs[3] = '{16'h0033, 16, 40'hFF_00_00_00_A5, 0, 0};
      vecs[4] = '{16'h8533, 16, 40'hFF_00_00_00_A5, 0, 1};
      vecs[5] = '{16'h8277, 15, 40'hFF_00_00_00_A5, 0, 1};
      vecs[6] = '{16'h8277, 17, 40'hFF_00_00_00_A5, 0, 1};
      vecs[7] = '{16'h8155, 16, 40'hFF_00_00_55_A5, 1, 0};

      tick(3);
      @(negedge clk);
      check("reset_regs", regs_act, 40'h0);
      check("reset_strobes", {38'h0, wr_strobe, err_strobe}, 40'h0);
      tick(1);
      rst_n = 1'b1;
      tick(5);

      foreach (vecs[i]) begin
         wr0 = wr_cnt; err0 = err_cnt;
         frame(vecs[i].word, vecs[i].nbits, 20);
         check($sformatf("v%0d_regs", i), regs_act, vecs[i].exp_regs);
         check($sformatf("v%0d_wr", i), 40'(wr_cnt - wr0), 40'(vecs[i].exp_wr));
         check($sformatf("v%0d_err", i), 40'(err_cnt - err0), 40'(vecs[i].exp_err));
      end

      // Commit latency: edge N is the first posedge after ncs goes high.
      send_bits(16'h8166, 16);
      ncs = 1'b1;
      k = 0;
      while (k < 50) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         if (wr_strobe) break;
      end
      check("latency", 40'(k - 1), 40'(SYNC_STAGES + 2));
      check("latency_reg", {32'h0, en_reg_out_15_8}, 40'h66);
      tick(20);

      // Reset mid-frame after 9 bits.
      send_bits(16'h83C3, 9);
      rst_n = 1'b0;
      tick(1);
      @(negedge clk);
      check("midreset_regs", regs_act, 40'h0);
      check("midreset_strobes", {38'h0, wr_strobe, err_strobe}, 40'h0);
      ncs = 1'b1;
      tick(3);
      rst_n = 1'b1;
      tick(5);
      wr0 = wr_cnt; err0 = err_cnt;
      frame(16'h83C3, 16, 20);
      check("after_reset_regs", regs_act, 40'h00_C3_00_00_00);
      check("after_reset_wr", 40'(wr_cnt - wr0), 40'd1);
      check("after_reset_err", 40'(err_cnt - err0), 40'd0);

      // Back-to-back frames; the 1-clk gap lands the next ncs fall in COMMIT.
      sb[0] = 8'h00; sb[1] = 8'h00; sb[2] = 8'h00; sb[3] = 8'hC3; sb[4] = 8'h00;
      wr0 = wr_cnt; err0 = err_cnt;
      for (int a = 0; a < 5; a++) begin
         d = 8'($urandom);
         sb[a] = d;
         frame({1'b1, 7'(a), d}, 16, (a == 2) ? 1 : 2);
      end
      tick(20);
      check("b2b_regs", regs_act, {sb[4], sb[3], sb[2], sb[1], sb[0]});
      check("b2b_wr", 40'(wr_cnt - wr0), 40'd5);
      check("b2b_err", 40'(err_cnt - err0), 40'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
